// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage data memory.
package mem_pkg;

   // Controller state: the hardware clear sweep after reset, then normal service.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_e;

   // Addresses are zero-extended to this width before range comparison,
   // so the address port may be up to 64 bits wide.
   localparam int unsigned ADDR_CMP_W = 64;

   // True when an access starting at addr fits entirely inside the array.
   // A wide access also touches addr+1, so its last legal start is depth-2.
   // There is no wrap-around: a wide access at depth-1 is out of range.
   function automatic logic addr_in_range(
      input logic [ADDR_CMP_W-1:0] addr,
      input logic                  wide,
      input int unsigned           depth
   );
      logic [ADDR_CMP_W-1:0] limit;
      limit = wide ? ADDR_CMP_W'(depth - 1) : ADDR_CMP_W'(depth);
      return addr < limit;
   endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear sequencer: after reset, zeroes one word per cycle from index 0 up to
// DEPTH-1, holding busy high until the edge that writes the last word.
module mem_clear_fsm
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned IDX_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   output logic             busy_o,
   output logic             clr_we_o,
   output logic [IDX_W-1:0] clr_addr_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   clr_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // State and clear-pointer register; reset restarts the sweep from index 0.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other register, independent of statement order.
      if (rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state and output decode; in CLEAR the pointer walks the array once.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d  = state_q;
      ptr_d    = ptr_q;
      busy_o   = 1'b0;
      clr_we_o = 1'b0;
      case (state_q)
         CLEAR: begin
            busy_o   = 1'b1;
            clr_we_o = 1'b1;
            if (ptr_q == LAST_IDX) begin
               state_d = READY;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + IDX_W'(1);
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   assign clr_addr_o = ptr_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage data memory: narrow and wide (two-word) accesses, one-cycle
// registered read with valid strobe, write-first forwarding per word, range
// checking with an error pulse, and a post-reset hardware clear sweep.
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic                rd_wide,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [2*DATA_W-1:0] rd_data,
   output logic                rd_valid,
   input  logic                wr_en,
   input  logic                wr_wide,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [2*DATA_W-1:0] wr_data,
   output logic                busy,
   output logic                addr_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   // Word-indexed storage so a wide write can update two words on one edge.
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic             clr_we;
   logic [IDX_W-1:0] clr_addr;

   mem_clear_fsm #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_clear_fsm (
      .clk        (clk),
      .rst        (rst),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // ---------------------------------------------------------------------
   // Request qualification
   // ---------------------------------------------------------------------
   logic ready;
   logic rd_ok, wr_ok;
   logic rd_go, wr_go;
   logic err_d;

   // Requests are only honoured in READY and never on a reset edge.
   assign ready = !busy && !rst;
   assign rd_ok = addr_in_range(ADDR_CMP_W'(rd_addr), rd_wide, DEPTH);
   assign wr_ok = addr_in_range(ADDR_CMP_W'(wr_addr), wr_wide, DEPTH);

   // An out-of-range read still completes (with zero data); an out-of-range
   // write is dropped as a whole, including any half that would fit.
   assign rd_go = ready && rd_en;
   assign wr_go = ready && wr_en && wr_ok;
   assign err_d = ready && ((rd_en && !rd_ok) || (wr_en && !wr_ok));

   // ---------------------------------------------------------------------
   // Word-level write ports: word 0 at a, word 1 at a+1 (wide only).
   // The high half of wide data lands at the lower address.
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]  wr_idx0, wr_idx1;
   logic [DATA_W-1:0] wr_word0, wr_word1;

   assign wr_idx0  = wr_addr[IDX_W-1:0];
   assign wr_idx1  = wr_idx0 + IDX_W'(1);
   assign wr_word0 = wr_wide ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
   assign wr_word1 = wr_data[DATA_W-1:0];

   // Storage update: the clear sweep owns the array while busy, user writes otherwise.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch; its contents are zeroed by the
      // clear sweep, which keeps it mappable to plain RAM.
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_go) begin
         mem_q[wr_idx0] <= wr_word0;
         if (wr_wide) begin
            mem_q[wr_idx1] <= wr_word1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read path with write-first forwarding, resolved independently per word
   // so a partially overlapping wide write forwards only the shared word.
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]    rd_idx0, rd_idx1;
   logic [DATA_W-1:0]   rd_word0, rd_word1;
   logic [2*DATA_W-1:0] rd_data_d, rd_data_q;
   logic                rd_valid_q, addr_err_q;

   assign rd_idx0 = rd_addr[IDX_W-1:0];
   assign rd_idx1 = rd_idx0 + IDX_W'(1);

   // Select each read word from the array or from a same-cycle write to that word.
   always_comb begin
      rd_word0 = mem_q[rd_idx0];
      rd_word1 = mem_q[rd_idx1];
      if (wr_go && (rd_idx0 == wr_idx0)) begin
         rd_word0 = wr_word0;
      end else if (wr_go && wr_wide && (rd_idx0 == wr_idx1)) begin
         rd_word0 = wr_word1;
      end
      if (wr_go && (rd_idx1 == wr_idx0)) begin
         rd_word1 = wr_word0;
      end else if (wr_go && wr_wide && (rd_idx1 == wr_idx1)) begin
         rd_word1 = wr_word1;
      end
   end

   // Assemble the read result; out-of-range reads return zero.
   always_comb begin
      rd_data_d = '0;
      if (rd_ok) begin
         if (rd_wide) begin
            rd_data_d = {rd_word0, rd_word1};
         end else begin
            rd_data_d = {{DATA_W{1'b0}}, rd_word0};
         end
      end
   end

   // Output registers: data holds until the next accepted read; strobes last one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_go;
         addr_err_q <= err_d;
         if (rd_go) begin
            rd_data_q <= rd_data_d;
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (DEPTH = 16): directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_data_mem_ctrl;

   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_en, rd_wide, wr_en, wr_wide;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [2*DW-1:0] wr_data, rd_data;
   logic          rd_valid, busy, addr_err;

   always #5 clk = ~clk;

   data_mem_ctrl #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .rd_wide  (rd_wide),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_en    (wr_en),
      .wr_wide  (wr_wide),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .addr_err (addr_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   logic [DW-1:0]   m_mem [DEPTH];
   int              clear_left;
   logic [2*DW-1:0] e_rd_data;
   logic            e_rd_valid, e_addr_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit fits(input logic [AW-1:0] a, input logic wide);
      return wide ? (a < AW'(DEPTH - 1)) : (a < AW'(DEPTH));
   endfunction

   // Model one clock edge from the currently driven inputs. A write is applied
   // before the read is evaluated, which is exactly write-first semantics.
   task automatic model_edge();
      bit rok, wok;
      int wa, ra;
      rok = fits(rd_addr, rd_wide);
      wok = fits(wr_addr, wr_wide);
      wa  = int'(wr_addr);
      ra  = int'(rd_addr);
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         clear_left = DEPTH;
         e_rd_data  = '0;
         e_rd_valid = 1'b0;
         e_addr_err = 1'b0;
      end else if (clear_left > 0) begin
         clear_left--;
         e_rd_valid = 1'b0;
         e_addr_err = 1'b0;
      end else begin
         if (wr_en && wok) begin
            if (wr_wide) begin
               m_mem[wa]     = wr_data[2*DW-1:DW];
               m_mem[wa + 1] = wr_data[DW-1:0];
            end else begin
               m_mem[wa] = wr_data[DW-1:0];
            end
         end
         e_rd_valid = rd_en;
         if (rd_en) begin
            if (!rok)         e_rd_data = '0;
            else if (rd_wide) e_rd_data = {m_mem[ra], m_mem[ra + 1]};
            else              e_rd_data = {{DW{1'b0}}, m_mem[ra]};
         end
         e_addr_err = (rd_en && !rok) || (wr_en && !wok);
      end
   endtask

   // Advance one clock with the current inputs and compare all outputs.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("busy",     64'(busy),     64'(clear_left > 0));
      check("rd_valid", 64'(rd_valid), 64'(e_rd_valid));
      check("rd_data",  64'(rd_data),  64'(e_rd_data));
      check("addr_err", 64'(addr_err), 64'(e_addr_err));
   endtask

   task automatic idle();
      rd_en = 1'b0; rd_wide = 1'b0; rd_addr = '0;
      wr_en = 1'b0; wr_wide = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic do_write(input int a, input logic wide, input logic [2*DW-1:0] d);
      idle();
      wr_en = 1'b1; wr_wide = wide; wr_addr = AW'(a); wr_data = d;
      cycle();
      idle();
   endtask

   task automatic do_read(input int a, input logic wide);
      idle();
      rd_en = 1'b1; rd_wide = wide; rd_addr = AW'(a);
      cycle();
      idle();
   endtask

   // Drop rst and count cycles until busy falls, bounded.
   task automatic count_clear(input string tag, input int exp_len);
      int cnt;
      cnt = 0;
      rst = 1'b0;
      while (busy && cnt < 40) begin
         cycle();
         cnt++;
      end
      check(tag, 64'(cnt), 64'(exp_len));
   endtask

   initial begin
      idle();
      clear_left = 0;
      e_rd_data = '0; e_rd_valid = 1'b0; e_addr_err = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;

      // Reset state
      rst = 1'b1;
      @(negedge clk);
      cycle();
      cycle();
      check("reset_busy", 64'(busy), 64'd1);
      count_clear("clear_len_0", DEPTH);

      // Preload mem[5], reset again, confirm it is cleared
      do_write(5, 1'b0, 32'h0000_BEEF);
      do_read(5, 1'b0);
      check("preload", 64'(rd_data), 64'h0000_BEEF);
      rst = 1'b1;
      cycle();
      count_clear("clear_len_1", DEPTH);
      do_read(5, 1'b0);
      check("cleared_valid", 64'(rd_valid), 64'd1);
      check("cleared_data",  64'(rd_data),  64'd0);

      // Wide round-trip
      do_write(4, 1'b1, 32'h1234_5678);
      do_read(4, 1'b0);
      check("wide_hi_word", 64'(rd_data), 64'h1234);
      do_read(5, 1'b0);
      check("wide_lo_word", 64'(rd_data), 64'h5678);
      do_read(4, 1'b1);
      check("wide_read", 64'(rd_data), 64'h1234_5678);

      // Collisions: same address, then partial overlap
      idle();
      wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0000_AAAA;
      rd_en = 1'b1; rd_addr = 3;
      cycle();
      check("coll_same", 64'(rd_data), 64'h0000_AAAA);
      do_write(2, 1'b0, 32'h0000_2222);
      idle();
      wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0000_0F0F;
      rd_en = 1'b1; rd_wide = 1'b1; rd_addr = 2;
      cycle();
      check("coll_partial", 64'(rd_data), 64'h2222_0F0F);
      idle();
      wr_en = 1'b1; wr_wide = 1'b1; wr_addr = 7; wr_data = 32'hCAFE_D00D;
      rd_en = 1'b1; rd_wide = 1'b1; rd_addr = 6;
      cycle();
      check("coll_wide_overlap", 64'(rd_data[DW-1:0]), 64'hCAFE);

      // Range checks
      do_write(15, 1'b0, 32'h0000_5A5A);
      do_write(15, 1'b1, 32'h1111_2222);
      check("wide15_err", 64'(addr_err), 64'd1);
      cycle();
      check("err_one_pulse", 64'(addr_err), 64'd0);
      do_read(15, 1'b0);
      check("wide15_kept", 64'(rd_data), 64'h5A5A);
      do_read(20, 1'b0);
      check("oor_rd_valid", 64'(rd_valid), 64'd1);
      check("oor_rd_data",  64'(rd_data),  64'd0);
      check("oor_rd_err",   64'(addr_err), 64'd1);
      idle();
      rd_en = 1'b1; rd_addr = 30; wr_en = 1'b1; wr_addr = 40;
      cycle();
      idle();
      cycle();
      check("both_oor_single", 64'(addr_err), 64'd0);
      do_read(14, 1'b1);
      do_read(15, 1'b1);

      // Back-to-back reads
      for (int i = 0; i < 6; i++) begin
         rd_en = 1'b1; rd_wide = 1'b0; rd_addr = AW'(i);
         cycle();
         check("b2b_valid", 64'(rd_valid), 64'd1);
      end
      idle();

      // Busy gating and mid-clear reset
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 1; wr_data = 32'h0000_1234;
      for (int i = 0; i < 7; i++) cycle();
      idle();
      rst = 1'b1;
      cycle();
      count_clear("clear_len_mid", DEPTH);
      do_read(1, 1'b0);
      check("gated_write", 64'(rd_data), 64'd0);

      // Read in flight killed by reset
      rd_en = 1'b1; rd_addr = 2; rst = 1'b1;
      cycle();
      check("rst_kills_valid", 64'(rd_valid), 64'd0);
      idle();
      count_clear("clear_len_2", DEPTH);

      // Randomized traffic with biased collisions and rare resets
      for (int n = 0; n < 600; n++) begin
         rst     = ($urandom_range(0, 249) == 0);
         wr_en   = $urandom_range(0, 1);
         wr_wide = $urandom_range(0, 1);
         wr_addr = AW'($urandom_range(0, 19));
         wr_data = $urandom;
         rd_en   = $urandom_range(0, 1);
         rd_wide = $urandom_range(0, 1);
         if ($urandom_range(0, 1) == 1) rd_addr = wr_addr + AW'($urandom_range(0, 2)) - AW'(1);
         else                           rd_addr = AW'($urandom_range(0, 19));
         cycle();
      end
      rst = 1'b0;
      idle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
